// File: rtl/writeback_arbiter.sv
// Writeback arbiter: per-source result FIFOs merged by round-robin into a single
// registered register-file write port, with a scoreboard-style hazard query for decode.
module writeback_arbiter #(
  parameter int unsigned NUM_SRC = 3,
  parameter int unsigned XLEN    = 32,
  parameter int unsigned DEPTH   = 2
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    flush,
  input  logic [NUM_SRC-1:0]      src_valid,
  output logic [NUM_SRC-1:0]      src_ready,
  input  logic [NUM_SRC*5-1:0]    src_rd,
  input  logic [NUM_SRC*XLEN-1:0] src_data,
  input  logic [4:0]              hazard_rd,
  output logic                    hazard_pending,
  output logic [4:0]              wb_rd_addr,
  output logic [XLEN-1:0]         wb_rd_data,
  output logic                    wb_rd_we,
  output logic                    idle
);

  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = $clog2(DEPTH + 1);
  localparam int unsigned IW = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;

  logic [CW-1:0]    cnt_q  [NUM_SRC];
  logic [CW-1:0]    cnt_d  [NUM_SRC];
  logic [PW-1:0]    wptr_q [NUM_SRC];
  logic [PW-1:0]    wptr_d [NUM_SRC];
  logic [PW-1:0]    rptr_q [NUM_SRC];
  logic [PW-1:0]    rptr_d [NUM_SRC];
  logic [DEPTH-1:0] vld_q  [NUM_SRC];
  logic [DEPTH-1:0] vld_d  [NUM_SRC];
  logic [4:0]       rd_mem   [NUM_SRC][DEPTH];
  logic [XLEN-1:0]  data_mem [NUM_SRC][DEPTH];

  logic [IW-1:0]    rr_q, rr_d;
  logic [4:0]       wb_addr_q, wb_addr_d;
  logic [XLEN-1:0]  wb_data_q, wb_data_d;
  logic             wb_we_q, wb_we_d;

  logic [NUM_SRC-1:0] push, pop;
  logic               gnt_vld;
  logic [IW-1:0]      gnt_idx;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  // rd==0 results are accepted but dropped: x0 is never written.
  always_comb begin
    for (int i = 0; i < NUM_SRC; i++) begin
      src_ready[i] = rst_n & ~flush & (cnt_q[i] < CW'(DEPTH));
      push[i]      = src_valid[i] & src_ready[i] & (src_rd[5*i +: 5] != 5'd0);
    end
  end

  // Scan farthest-to-nearest so the nearest non-empty queue after rr_q wins.
  always_comb begin
    int unsigned idx;
    idx     = 0;
    gnt_vld = 1'b0;
    gnt_idx = '0;
    for (int unsigned k = NUM_SRC; k >= 1; k--) begin
      idx = (32'(rr_q) + k) % NUM_SRC;
      if (cnt_q[IW'(idx)] != '0) begin
        gnt_vld = 1'b1;
        gnt_idx = IW'(idx);
      end
    end
    for (int i = 0; i < NUM_SRC; i++) begin
      pop[i] = gnt_vld & ~flush & (gnt_idx == IW'(i));
    end
  end

  always_comb begin
    for (int i = 0; i < NUM_SRC; i++) begin
      cnt_d[i]  = cnt_q[i];
      wptr_d[i] = wptr_q[i];
      rptr_d[i] = rptr_q[i];
      vld_d[i]  = vld_q[i];
      if (flush) begin
        cnt_d[i]  = '0;
        wptr_d[i] = '0;
        rptr_d[i] = '0;
        vld_d[i]  = '0;
      end else begin
        if (pop[i]) begin
          rptr_d[i]            = ptr_inc(rptr_q[i]);
          vld_d[i][rptr_q[i]]  = 1'b0;
        end
        if (push[i]) begin
          wptr_d[i]            = ptr_inc(wptr_q[i]);
          vld_d[i][wptr_q[i]]  = 1'b1;
        end
        unique case ({push[i], pop[i]})
          2'b10:   cnt_d[i] = cnt_q[i] + CW'(1);
          2'b01:   cnt_d[i] = cnt_q[i] - CW'(1);
          default: cnt_d[i] = cnt_q[i];
        endcase
      end
    end
  end

  always_comb begin
    rr_d      = rr_q;
    wb_addr_d = wb_addr_q;
    wb_data_d = wb_data_q;
    wb_we_d   = 1'b0;
    if (flush) begin
      rr_d = IW'(NUM_SRC - 1);
    end else if (gnt_vld) begin
      rr_d      = gnt_idx;
      wb_we_d   = 1'b1;
      wb_addr_d = rd_mem[gnt_idx][rptr_q[gnt_idx]];
      wb_data_d = data_mem[gnt_idx][rptr_q[gnt_idx]];
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_SRC; i++) begin
      if (push[i]) begin
        rd_mem[i][wptr_q[i]]   <= src_rd[5*i +: 5];
        data_mem[i][wptr_q[i]] <= src_data[XLEN*i +: XLEN];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_SRC; i++) begin
        cnt_q[i]  <= '0;
        wptr_q[i] <= '0;
        rptr_q[i] <= '0;
        vld_q[i]  <= '0;
      end
      rr_q      <= IW'(NUM_SRC - 1);
      wb_addr_q <= '0;
      wb_data_q <= '0;
      wb_we_q   <= 1'b0;
    end else begin
      for (int i = 0; i < NUM_SRC; i++) begin
        cnt_q[i]  <= cnt_d[i];
        wptr_q[i] <= wptr_d[i];
        rptr_q[i] <= rptr_d[i];
        vld_q[i]  <= vld_d[i];
      end
      rr_q      <= rr_d;
      wb_addr_q <= wb_addr_d;
      wb_data_q <= wb_data_d;
      wb_we_q   <= wb_we_d;
    end
  end

  // A register stays pending from enqueue until its writeback has been presented.
  always_comb begin
    logic hit;
    logic busy;
    hit  = wb_we_q & (wb_addr_q == hazard_rd);
    busy = wb_we_q;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (cnt_q[i] != '0) busy = 1'b1;
      for (int j = 0; j < DEPTH; j++) begin
        if (vld_q[i][j] && (rd_mem[i][j] == hazard_rd)) hit = 1'b1;
      end
    end
    hazard_pending = (hazard_rd != 5'd0) & hit;
    idle           = ~busy;
  end

  assign wb_rd_addr = wb_addr_q;
  assign wb_rd_data = wb_data_q;
  assign wb_rd_we   = wb_we_q;

endmodule

// File: tb/tb_writeback_arbiter.sv
// Bench for writeback_arbiter: queue-based reference model checked every cycle,
// plus directed scenarios with hand-computed literal expectations.
module tb_writeback_arbiter;

  localparam int NUM_SRC = 3;
  localparam int XLEN    = 32;
  localparam int DEPTH   = 2;

  typedef struct packed {
    logic [4:0]      rd;
    logic [XLEN-1:0] data;
  } ent_t;

  logic                    clk = 1'b0;
  logic                    rst_n = 1'b1;
  logic                    flush = 1'b0;
  logic [NUM_SRC-1:0]      src_valid = '0;
  logic [NUM_SRC-1:0]      src_ready;
  logic [NUM_SRC*5-1:0]    src_rd = '0;
  logic [NUM_SRC*XLEN-1:0] src_data = '0;
  logic [4:0]              hazard_rd = '0;
  logic                    hazard_pending;
  logic [4:0]              wb_rd_addr;
  logic [XLEN-1:0]         wb_rd_data;
  logic                    wb_rd_we;
  logic                    idle;

  int checks = 0;
  int failures = 0;
  bit chk_en = 1'b0;

  writeback_arbiter #(
    .NUM_SRC(NUM_SRC),
    .XLEN   (XLEN),
    .DEPTH  (DEPTH)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .flush         (flush),
    .src_valid     (src_valid),
    .src_ready     (src_ready),
    .src_rd        (src_rd),
    .src_data      (src_data),
    .hazard_rd     (hazard_rd),
    .hazard_pending(hazard_pending),
    .wb_rd_addr    (wb_rd_addr),
    .wb_rd_data    (wb_rd_data),
    .wb_rd_we      (wb_rd_we),
    .idle          (idle)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  // Reference model: one queue per source, round-robin pointer, registered write port.
  ent_t            mq [NUM_SRC][$];
  int              m_rr = NUM_SRC - 1;
  logic            m_we = 1'b0;
  logic [4:0]      m_addr = '0;
  logic [XLEN-1:0] m_data = '0;
  int              m_sz [NUM_SRC];
  ent_t            m_ent;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n || flush) begin
      for (int i = 0; i < NUM_SRC; i++) mq[i].delete();
      m_we = 1'b0;
      m_rr = NUM_SRC - 1;
      if (!rst_n) begin
        m_addr = '0;
        m_data = '0;
      end
    end else begin
      for (int i = 0; i < NUM_SRC; i++) m_sz[i] = mq[i].size();
      m_we = 1'b0;
      for (int k = 1; k <= NUM_SRC; k++) begin
        int s;
        s = (m_rr + k) % NUM_SRC;
        if (!m_we && m_sz[s] > 0) begin
          m_ent  = mq[s].pop_front();
          m_we   = 1'b1;
          m_addr = m_ent.rd;
          m_data = m_ent.data;
          m_rr   = s;
        end
      end
      for (int i = 0; i < NUM_SRC; i++) begin
        if (src_valid[i] && m_sz[i] < DEPTH && src_rd[5*i +: 5] != 5'd0)
          mq[i].push_back({src_rd[5*i +: 5], src_data[XLEN*i +: XLEN]});
      end
    end
  end

  logic [4:0] dut_log [$];

  always @(negedge clk) begin
    if (chk_en) begin
      logic [NUM_SRC-1:0] e_ready;
      logic               e_haz, e_idle;
      e_haz  = m_we && (m_addr == hazard_rd);
      e_idle = !m_we;
      for (int i = 0; i < NUM_SRC; i++) begin
        e_ready[i] = rst_n && !flush && (mq[i].size() < DEPTH);
        if (mq[i].size() != 0) e_idle = 1'b0;
        foreach (mq[i][j]) if (mq[i][j].rd == hazard_rd) e_haz = 1'b1;
      end
      e_haz = e_haz && (hazard_rd != 5'd0);
      check("m_src_ready", 64'(src_ready), 64'(e_ready));
      check("m_hazard", 64'(hazard_pending), 64'(e_haz));
      check("m_idle", 64'(idle), 64'(e_idle));
      check("m_we", 64'(wb_rd_we), 64'(m_we));
      check("m_addr", 64'(wb_rd_addr), 64'(m_addr));
      check("m_data", 64'(wb_rd_data), 64'(m_data));
      check("we_addr_nonzero", 64'(wb_rd_we && wb_rd_addr == 5'd0), 64'd0);
      if (wb_rd_we) dut_log.push_back(wb_rd_addr);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_src(input int s, input logic v, input logic [4:0] rd,
                         input logic [XLEN-1:0] d);
    src_valid[s]          = v;
    src_rd[5*s +: 5]      = rd;
    src_data[XLEN*s +: XLEN] = d;
  endtask

  task automatic wait_idle();
    for (int n = 0; n < 40 && !idle; n++) tick();
    check("idle_within_bound", 64'(idle), 64'd1);
  endtask

  // Three entries then two more: four left queued after one grant.
  task automatic load_four();
    set_src(0, 1'b1, 5'd1, 32'h1111_0000);
    set_src(1, 1'b1, 5'd2, 32'h2222_0000);
    set_src(2, 1'b1, 5'd3, 32'h3333_0000);
    tick();
    set_src(0, 1'b0, 5'd0, 32'h0);
    set_src(1, 1'b1, 5'd4, 32'h2222_0001);
    set_src(2, 1'b1, 5'd5, 32'h3333_0001);
    tick();
    src_valid = '0;
  endtask

  task automatic src0_first(input string tag);
    set_src(0, 1'b1, 5'd1, 32'hAAAA_0000);
    set_src(1, 1'b1, 5'd2, 32'hBBBB_0000);
    set_src(2, 1'b1, 5'd3, 32'hCCCC_0000);
    tick();
    src_valid = '0;
    tick();
    check({tag, "_first_we"}, 64'(wb_rd_we), 64'd1);
    check({tag, "_first_addr"}, 64'(wb_rd_addr), 64'd1);
    check({tag, "_first_data"}, 64'(wb_rd_data), 64'hAAAA_0000);
    wait_idle();
  endtask

  initial begin
    #1 rst_n = 1'b0;
    chk_en = 1'b1;
    hazard_rd = 5'd7;
    repeat (2) tick();
    check("rst_we", 64'(wb_rd_we), 64'd0);
    check("rst_addr", 64'(wb_rd_addr), 64'd0);
    check("rst_ready", 64'(src_ready), 64'd0);
    check("rst_idle", 64'(idle), 64'd1);
    check("rst_hazard", 64'(hazard_pending), 64'd0);
    rst_n = 1'b1;
    #1 check("rel_ready", 64'(src_ready), 64'b111);

    // Single push on source 0.
    tick();
    set_src(0, 1'b1, 5'd5, 32'hDEAD_BEEF);
    hazard_rd = 5'd5;
    tick();
    src_valid = '0;
    check("s1_we_edgeN", 64'(wb_rd_we), 64'd0);
    check("s1_haz_queued", 64'(hazard_pending), 64'd1);
    tick();
    check("s1_we", 64'(wb_rd_we), 64'd1);
    check("s1_addr", 64'(wb_rd_addr), 64'd5);
    check("s1_data", 64'(wb_rd_data), 64'hDEAD_BEEF);
    tick();
    check("s1_we_off", 64'(wb_rd_we), 64'd0);
    check("s1_idle", 64'(idle), 64'd1);

    // rd==0 is consumed silently.
    hazard_rd = 5'd0;
    set_src(2, 1'b1, 5'd0, 32'h0000_1234);
    #1 check("x0_ready", 64'(src_ready[2]), 64'd1);
    tick();
    src_valid = '0;
    check("x0_we", 64'(wb_rd_we), 64'd0);
    check("x0_idle", 64'(idle), 64'd1);
    tick();
    check("x0_we_next", 64'(wb_rd_we), 64'd0);
    check("x0_idle_next", 64'(idle), 64'd1);

    // Flush to put the round-robin pointer back at NUM_SRC-1.
    flush = 1'b1;
    tick();
    flush = 1'b0;

    // All sources valid for 6 cycles with rd=src+1.
    dut_log.delete();
    for (int c = 0; c < 6; c++) begin
      for (int s = 0; s < NUM_SRC; s++)
        set_src(s, 1'b1, 5'(s + 1), {8'(c), 8'(s), 16'hA5A5});
      tick();
      if (c == 1) check("rr_src1_full_ready", 64'(src_ready), 64'b001);
    end
    src_valid = '0;
    wait_idle();
    check("rr_total_wb", 64'(dut_log.size()), 64'd10);
    for (int k = 0; k < 6 && k < dut_log.size(); k++)
      check($sformatf("rr_order_%0d", k), 64'(dut_log[k]), 64'((k % 3) + 1));

    // Hazard tracking for rd=7 on source 1.
    hazard_rd = 5'd7;
    set_src(1, 1'b1, 5'd7, 32'h7777_7777);
    tick();
    src_valid = '0;
    check("hz_queued", 64'(hazard_pending), 64'd1);
    hazard_rd = 5'd0;
    #1 check("hz_rd0", 64'(hazard_pending), 64'd0);
    hazard_rd = 5'd7;
    tick();
    check("hz_wb_we", 64'(wb_rd_we), 64'd1);
    check("hz_wb_cycle", 64'(hazard_pending), 64'd1);
    tick();
    check("hz_cleared", 64'(hazard_pending), 64'd0);

    // Flush with four entries queued.
    hazard_rd = 5'd2;
    load_four();
    flush = 1'b1;
    #1 check("fl_ready", 64'(src_ready), 64'd0);
    tick();
    flush = 1'b0;
    check("fl_we", 64'(wb_rd_we), 64'd0);
    check("fl_idle", 64'(idle), 64'd1);
    src0_first("fl");

    // Same again with an asynchronous reset pulse mid-burst.
    load_four();
    rst_n = 1'b0;
    #1;
    check("ar_we", 64'(wb_rd_we), 64'd0);
    check("ar_ready", 64'(src_ready), 64'd0);
    check("ar_idle", 64'(idle), 64'd1);
    check("ar_hazard", 64'(hazard_pending), 64'd0);
    #1 rst_n = 1'b1;
    tick();
    check("ar_we_after", 64'(wb_rd_we), 64'd0);
    check("ar_ready_after", 64'(src_ready), 64'b111);
    src0_first("ar");

    tick();
    chk_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
